// File: rtl/eth_rx_frame_fsm.sv
// eth_rx_frame_fsm: MII receive framer that strips preamble/SFD, forwards DA..FCS and grades each frame.
// Optional CRC-32 FCS checking is compiled in when the macro ETH_RX_CRC_CHECK_EN is defined.
module eth_rx_frame_fsm #(
    parameter int pMEM_WIDTH    = 8,
    parameter int pLEN_WIDTH    = 16,
    parameter int pMIN_PREAMBLE = 7,
    parameter int pMIN_LEN      = 64,
    parameter int pMAX_LEN      = 1518
) (
    input  logic                  iclk,
    input  logic                  i_rst,
    input  logic                  irx_dv,
    input  logic                  irx_er,
    input  logic [pMEM_WIDTH-1:0] irx_d,
    output logic [2:0]            ostate,
    output logic                  odv,
    output logic [pMEM_WIDTH-1:0] od,
    output logic [pLEN_WIDTH-1:0] olen,
    output logic                  oframe_end,
    output logic                  ogood,
    output logic [1:0]            oerr_code
);

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        PREAMBLE = 3'b001,
        DATA     = 3'b011,
        DONE     = 3'b100,
        DROP     = 3'b101
    } state_t;

    localparam logic [pMEM_WIDTH-1:0] PRE_BYTE  = pMEM_WIDTH'(8'h55);
    localparam logic [pMEM_WIDTH-1:0] SFD_BYTE  = pMEM_WIDTH'(8'hD5);
    localparam logic [2:0]            MIN_PRE   = 3'(pMIN_PREAMBLE);
    localparam logic [2:0]            PRE_SAT   = 3'd7;
    localparam logic [pLEN_WIDTH-1:0] MIN_LEN   = pLEN_WIDTH'(pMIN_LEN);
    localparam logic [pLEN_WIDTH-1:0] MAX_LEN   = pLEN_WIDTH'(pMAX_LEN);
    localparam logic [1:0]            ERR_OK    = 2'b00;
    localparam logic [1:0]            ERR_RUNT  = 2'b01;
    localparam logic [1:0]            ERR_CRC   = 2'b10;
    localparam logic [1:0]            ERR_ABORT = 2'b11;

    state_t     state;
    state_t     state_next;
    logic [2:0] pre_cnt;
    logic       pre_start;
    logic       pre_inc;
    logic       sfd_hit;
    logic       fwd;
    logic       close;
    logic       abort;
    logic       crc_pass;
    logic [1:0] verdict_code;

    always_ff @(posedge iclk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign ostate = state;

    // Next-state decode; the strobes tell the datapath what this edge does to the frame.
    always_comb begin
        state_next = state;
        pre_start  = 1'b0;
        pre_inc    = 1'b0;
        sfd_hit    = 1'b0;
        fwd        = 1'b0;
        close      = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (irx_dv) begin
                    if (irx_d == PRE_BYTE) begin
                        state_next = PREAMBLE;
                        pre_start  = 1'b1;
                    end else begin
                        state_next = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!irx_dv) begin
                    state_next = IDLE;
                end else if (irx_er) begin
                    state_next = DROP;
                end else if (irx_d == PRE_BYTE) begin
                    pre_inc = (pre_cnt != PRE_SAT);
                end else if ((irx_d == SFD_BYTE) && (pre_cnt >= MIN_PRE)) begin
                    state_next = DATA;
                    sfd_hit    = 1'b1;
                end else begin
                    state_next = DROP;
                end
            end
            DATA: begin
                if (irx_er || (irx_dv && (olen == MAX_LEN))) begin
                    state_next = DROP;
                    abort      = 1'b1;
                end else if (!irx_dv) begin
                    state_next = DONE;
                    close      = 1'b1;
                end else begin
                    fwd = 1'b1;
                end
            end
            DONE: begin
                state_next = irx_dv ? DROP : IDLE;
            end
            DROP: begin
                if (!irx_dv) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk or posedge i_rst) begin
        if (i_rst) begin
            pre_cnt <= 3'd0;
        end else if (pre_start) begin
            pre_cnt <= 3'd1;
        end else if (pre_inc) begin
            pre_cnt <= pre_cnt + 3'd1;
        end
    end

    // Runt outranks a CRC failure, so a short frame never reports code 10.
    always_comb begin
        verdict_code = ERR_OK;
        if (olen < MIN_LEN) begin
            verdict_code = ERR_RUNT;
        end else if (!crc_pass) begin
            verdict_code = ERR_CRC;
        end
    end

    always_ff @(posedge iclk or posedge i_rst) begin
        if (i_rst) begin
            odv        <= 1'b0;
            od         <= '0;
            olen       <= '0;
            oframe_end <= 1'b0;
            ogood      <= 1'b0;
            oerr_code  <= ERR_OK;
        end else begin
            odv        <= fwd;
            oframe_end <= close | abort;
            if (sfd_hit) begin
                olen <= '0;
            end else if (fwd) begin
                olen <= olen + pLEN_WIDTH'(1);
            end
            if (fwd) begin
                od <= irx_d;
            end
            if (close) begin
                ogood     <= (verdict_code == ERR_OK);
                oerr_code <= verdict_code;
            end else if (abort) begin
                ogood     <= 1'b0;
                oerr_code <= ERR_ABORT;
            end
        end
    end

`ifdef ETH_RX_CRC_CHECK_EN
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    logic [31:0] crc;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [pMEM_WIDTH-1:0] d);
        logic [31:0] r;
        r = c ^ 32'(d);
        for (int b = 0; b < pMEM_WIDTH; b++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // Running over the FCS too leaves the fixed residue when the frame is intact.
    always_ff @(posedge iclk or posedge i_rst) begin
        if (i_rst) begin
            crc <= CRC_INIT;
        end else if (sfd_hit) begin
            crc <= CRC_INIT;
        end else if (fwd) begin
            crc <= crc_step(crc, irx_d);
        end
    end

    assign crc_pass = (crc == CRC_RESIDUE);
`else
    assign crc_pass = 1'b1;
`endif

endmodule

// File: tb/tb_eth_rx_frame_fsm.sv
// tb_eth_rx_frame_fsm: randomized frame stimulus checked cycle by cycle against a frame-level model.
// Honours ETH_RX_CRC_CHECK_EN the same way the design does.
module tb_eth_rx_frame_fsm;

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_PRE  = 3'b001;
    localparam logic [2:0] S_DATA = 3'b011;
    localparam logic [2:0] S_DONE = 3'b100;
    localparam logic [2:0] S_DROP = 3'b101;
    localparam int EXP_SIZE = 32768;
`ifdef ETH_RX_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    typedef struct {
        bit          valid;
        logic [2:0]  st;
        bit          dv;
        logic [7:0]  d;
        logic [15:0] len;
        bit          fend;
        bit          good;
        logic [1:0]  code;
    } exp_t;

    logic        iclk;
    logic        i_rst;
    logic        irx_dv;
    logic        irx_er;
    logic [7:0]  irx_d;
    logic [2:0]  ostate;
    logic        odv;
    logic [7:0]  od;
    logic [15:0] olen;
    logic        oframe_end;
    logic        ogood;
    logic [1:0]  oerr_code;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;
    int obs_dv_cnt = 0;
    int obs_end_cnt = 0;
    logic [15:0] obs_len = '0;
    logic        obs_good = 1'b0;
    logic [1:0]  obs_code = 2'b00;

    exp_t        exp_q [0:EXP_SIZE-1];
    logic [7:0]  fbuf [0:1599];
    logic [2:0]  m_state;
    logic [15:0] m_len;

    eth_rx_frame_fsm dut (
        .iclk       (iclk),
        .i_rst      (i_rst),
        .irx_dv     (irx_dv),
        .irx_er     (irx_er),
        .irx_d      (irx_d),
        .ostate     (ostate),
        .odv        (odv),
        .od         (od),
        .olen       (olen),
        .oframe_end (oframe_end),
        .ogood      (ogood),
        .oerr_code  (oerr_code)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    always @(posedge iclk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h (edge %0d)", name, act, want, edge_cnt);
        end
    endtask

    // Single compare process: every model-predicted edge is checked half a clock later.
    always @(negedge iclk) begin
        exp_t cur;
        if (!i_rst && edge_cnt > 0) begin
            if (odv === 1'b1) obs_dv_cnt++;
            if (oframe_end === 1'b1) begin
                obs_end_cnt++;
                obs_len  = olen;
                obs_good = ogood;
                obs_code = oerr_code;
            end
            if (edge_cnt - 1 < EXP_SIZE) begin
                cur = exp_q[edge_cnt-1];
                if (cur.valid) begin
                    checkOutput("ostate", 32'(ostate), 32'(cur.st));
                    checkOutput("odv", 32'(odv), 32'(cur.dv));
                    checkOutput("olen", 32'(olen), 32'(cur.len));
                    checkOutput("oframe_end", 32'(oframe_end), 32'(cur.fend));
                    if (cur.dv) checkOutput("od", 32'(od), 32'(cur.d));
                    if (cur.fend) begin
                        checkOutput("ogood", 32'(ogood), 32'(cur.good));
                        checkOutput("oerr_code", 32'(oerr_code), 32'(cur.code));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference CRC-32 (reflected, init all ones, final inversion) of fbuf[0..n-1].
    function automatic logic [31:0] crc32(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, fbuf[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bit fcs_ok(input int n);
        return crc32(n - 4) == {fbuf[n-1], fbuf[n-2], fbuf[n-3], fbuf[n-4]};
    endfunction

    task automatic build_frame(input int n, input bit corrupt);
        logic [31:0] fcs;
        int pos;
        for (int i = 0; i < n - 4; i++) fbuf[i] = 8'($urandom);
        fcs = crc32(n - 4);
        fbuf[n-4] = fcs[7:0];
        fbuf[n-3] = fcs[15:8];
        fbuf[n-2] = fcs[23:16];
        fbuf[n-1] = fcs[31:24];
        if (corrupt) begin
            pos = $urandom_range(0, n - 5);
            fbuf[pos] = fbuf[pos] ^ (8'h01 << $urandom_range(0, 7));
        end
    endtask

    function automatic exp_t blank(input logic [2:0] st);
        exp_t e;
        e.valid = 1'b1;
        e.st    = st;
        e.dv    = 1'b0;
        e.d     = 8'h00;
        e.len   = m_len;
        e.fend  = 1'b0;
        e.good  = 1'b0;
        e.code  = 2'b00;
        return e;
    endfunction

    task automatic applyStimulus(input logic dv, input logic er, input logic [7:0] d, input exp_t e);
        irx_dv = dv;
        irx_er = er;
        irx_d  = d;
        if (edge_cnt < EXP_SIZE) exp_q[edge_cnt] = e;
        m_state = e.st;
        @(posedge iclk);
        #1;
    endtask

    // One frame episode: preamble, SFD, fbuf[0..nbytes-1], then an idle gap; expectations follow the frame rules.
    task automatic run_frame(input int npre, input logic [7:0] sfd, input int nbytes, input int er_at, input int gap);
        bit   dropped;
        exp_t e;
        dropped = (m_state == S_DONE);
        for (int i = 1; i <= npre; i++) applyStimulus(1'b1, 1'b0, 8'h55, blank(dropped ? S_DROP : S_PRE));
        if (!dropped && !(sfd == 8'hD5 && npre >= 7)) dropped = 1'b1;
        else if (!dropped) m_len = 16'd0;
        applyStimulus(1'b1, 1'b0, sfd, blank(dropped ? S_DROP : S_DATA));
        for (int j = 1; j <= nbytes; j++) begin
            if (dropped) begin
                e = blank(S_DROP);
            end else if (er_at == j || m_len == 16'd1518) begin
                dropped = 1'b1;
                e = blank(S_DROP);
                e.fend = 1'b1;
                e.code = 2'b11;
            end else begin
                m_len = m_len + 16'd1;
                e = blank(S_DATA);
                e.dv = 1'b1;
                e.d  = fbuf[j-1];
            end
            applyStimulus(1'b1, (er_at == j) ? 1'b1 : 1'b0, fbuf[j-1], e);
        end
        for (int g = 1; g <= gap; g++) begin
            if (g == 1 && !dropped) begin
                e = blank(S_DONE);
                e.fend = 1'b1;
                if (nbytes < 64) e.code = 2'b01;
                else if (CRC_EN && !fcs_ok(nbytes)) e.code = 2'b10;
                else begin
                    e.code = 2'b00;
                    e.good = 1'b1;
                end
            end else begin
                e = blank(S_IDLE);
            end
            applyStimulus(1'b0, 1'b0, 8'h00, e);
        end
    endtask

    initial begin
        int dv0;
        int end0;
        i_rst  = 1'b1;
        irx_dv = 1'b0;
        irx_er = 1'b0;
        irx_d  = 8'h00;
        m_state = S_IDLE;
        m_len   = 16'd0;
        #1;
        checkOutput("rst_ostate", 32'(ostate), 32'h0);
        checkOutput("rst_odv", 32'(odv), 32'h0);
        checkOutput("rst_od", 32'(od), 32'h0);
        checkOutput("rst_olen", 32'(olen), 32'h0);
        checkOutput("rst_frame_end", 32'(oframe_end), 32'h0);
        checkOutput("rst_ogood", 32'(ogood), 32'h0);
        checkOutput("rst_err_code", 32'(oerr_code), 32'h0);
        repeat (2) @(posedge iclk);
        #1;
        i_rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, blank(S_IDLE));
        applyStimulus(1'b0, 1'b0, 8'h00, blank(S_IDLE));

        // Good 64-byte frame.
        dv0 = obs_dv_cnt; end0 = obs_end_cnt;
        build_frame(64, 1'b0);
        run_frame(7, 8'hD5, 64, 0, 3);
        checkOutput("good_dv_cycles", 32'(obs_dv_cnt - dv0), 32'd64);
        checkOutput("good_ends", 32'(obs_end_cnt - end0), 32'd1);
        checkOutput("good_len", 32'(obs_len), 32'd64);
        checkOutput("good_verdict", 32'(obs_good), 32'd1);
        checkOutput("good_code", 32'(obs_code), 32'd0);

        // One flipped payload bit.
        build_frame(64, 1'b1);
        run_frame(7, 8'hD5, 64, 0, 3);
        checkOutput("flip_code", 32'(obs_code), CRC_EN ? 32'd2 : 32'd0);
        checkOutput("flip_verdict", 32'(obs_good), CRC_EN ? 32'd0 : 32'd1);

        // Short preamble: discarded silently.
        dv0 = obs_dv_cnt; end0 = obs_end_cnt;
        build_frame(64, 1'b0);
        run_frame(5, 8'hD5, 64, 0, 2);
        checkOutput("shortpre_dv_cycles", 32'(obs_dv_cnt - dv0), 32'd0);
        checkOutput("shortpre_ends", 32'(obs_end_cnt - end0), 32'd0);

        // Runt.
        build_frame(20, 1'b0);
        run_frame(7, 8'hD5, 20, 0, 2);
        checkOutput("runt_len", 32'(obs_len), 32'd20);
        checkOutput("runt_code", 32'(obs_code), 32'd1);
        checkOutput("runt_verdict", 32'(obs_good), 32'd0);

        // Receive error on byte 30.
        dv0 = obs_dv_cnt;
        build_frame(64, 1'b0);
        run_frame(7, 8'hD5, 64, 30, 2);
        checkOutput("er30_dv_cycles", 32'(obs_dv_cnt - dv0), 32'd29);
        checkOutput("er30_code", 32'(obs_code), 32'd3);
        checkOutput("er30_len", 32'(obs_len), 32'd29);

        // Oversize frame truncated at the maximum.
        dv0 = obs_dv_cnt;
        build_frame(1600, 1'b0);
        run_frame(8, 8'hD5, 1600, 0, 2);
        checkOutput("giant_dv_cycles", 32'(obs_dv_cnt - dv0), 32'd1518);
        checkOutput("giant_len", 32'(obs_len), 32'd1518);
        checkOutput("giant_code", 32'(obs_code), 32'd3);

        // Back-to-back frames with no inter-frame gap: the second is discarded.
        dv0 = obs_dv_cnt; end0 = obs_end_cnt;
        build_frame(64, 1'b0);
        run_frame(7, 8'hD5, 64, 0, 1);
        run_frame(7, 8'hD5, 64, 0, 2);
        checkOutput("ifg_dv_cycles", 32'(obs_dv_cnt - dv0), 32'd64);
        checkOutput("ifg_ends", 32'(obs_end_cnt - end0), 32'd1);

        // Reset in the middle of DATA.
        end0 = obs_end_cnt;
        build_frame(64, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 8'h55, blank(S_PRE));
        m_len = 16'd0;
        applyStimulus(1'b1, 1'b0, 8'hD5, blank(S_DATA));
        for (int j = 1; j <= 10; j++) begin
            exp_t e;
            m_len = m_len + 16'd1;
            e = blank(S_DATA);
            e.dv = 1'b1;
            e.d  = fbuf[j-1];
            applyStimulus(1'b1, 1'b0, fbuf[j-1], e);
        end
        #2;
        i_rst = 1'b1;
        #1;
        checkOutput("midrst_ostate", 32'(ostate), 32'h0);
        checkOutput("midrst_odv", 32'(odv), 32'h0);
        checkOutput("midrst_od", 32'(od), 32'h0);
        checkOutput("midrst_olen", 32'(olen), 32'h0);
        checkOutput("midrst_ogood", 32'(ogood), 32'h0);
        @(posedge iclk);
        #1;
        i_rst = 1'b0;
        m_state = S_IDLE;
        m_len   = 16'd0;
        applyStimulus(1'b1, 1'b0, 8'hAB, blank(S_DROP));
        applyStimulus(1'b1, 1'b0, 8'h55, blank(S_DROP));
        applyStimulus(1'b0, 1'b0, 8'h00, blank(S_IDLE));
        checkOutput("midrst_no_end", 32'(obs_end_cnt - end0), 32'd0);
        build_frame(64, 1'b0);
        run_frame(7, 8'hD5, 64, 0, 2);
        checkOutput("postrst_len", 32'(obs_len), 32'd64);
        checkOutput("postrst_verdict", 32'(obs_good), 32'd1);

        // Randomized frames.
        for (int k = 0; k < 30; k++) begin
            int n;
            int npre;
            int er_at;
            logic [7:0] sfd;
            n     = $urandom_range(20, 200);
            npre  = ($urandom_range(0, 7) == 0) ? 6 : $urandom_range(7, 10);
            sfd   = ($urandom_range(0, 15) == 0) ? 8'h5D : 8'hD5;
            er_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, n) : 0;
            build_frame(n, $urandom_range(0, 3) == 0);
            run_frame(npre, sfd, n, er_at, $urandom_range(1, 3));
        end
        applyStimulus(1'b0, 1'b0, 8'h00, blank(S_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
